// File: rtl/buf_fifo_pkg.sv
// Shared defaults and elaboration helpers for the buffer family.
package buf_fifo_pkg;

  localparam int unsigned BUF_DEF_WIDTH = 8;
  localparam int unsigned BUF_DEF_DEPTH = 4;

  // Smallest r with 2**r >= v; usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/buf_fifo_if.sv
// Producer/consumer handshake bundle for buf_fifo, with occupancy status.
interface buf_fifo_if
  import buf_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = BUF_DEF_WIDTH,
  parameter int unsigned DEPTH = BUF_DEF_DEPTH
);
  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [AW:0]      count;
  logic             full;
  logic             empty;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count, full, empty
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count, full, empty
  );
endinterface

// File: rtl/buf_fifo.sv
// Synchronous show-ahead FIFO with valid/ready on both sides, occupancy count and flush.
module buf_fifo
  import buf_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = BUF_DEF_WIDTH,
  parameter int unsigned DEPTH = BUF_DEF_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  buf_fifo_if.slave bus
);
  localparam int unsigned AW = clog2(DEPTH);

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("buf_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      cnt;
  logic             full_w;
  logic             empty_w;
  logic             push;
  logic             pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty_w = (wr_ptr == rd_ptr);
    full_w  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    push    = bus.in_valid & ~full_w & ~flush;
    pop     = bus.out_ready & ~empty_w & ~flush;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Head word is masked while empty so reset presents zero on out_data.
  always_comb begin
    bus.in_ready  = ~full_w;
    bus.out_valid = ~empty_w;
    bus.full      = full_w;
    bus.empty     = empty_w;
    bus.count     = cnt;
    bus.out_data  = empty_w ? '0 : mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: tb/tb_buf_fifo.sv
// Directed and random checks of buf_fifo against a queue-based reference model.
module tb_buf_fifo;
  import buf_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;

  always #5 clk = ~clk;

  buf_fifo_if #(.WIDTH(8),  .DEPTH(4)) fa ();
  buf_fifo_if #(.WIDTH(16), .DEPTH(8)) fb ();

  buf_fifo #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(fa.slave)
  );

  buf_fifo #(.WIDTH(16), .DEPTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(fb.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0]  qa [$];
  logic [15:0] qb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the 8x4 FIFO: drive, check status against the model, then advance.
  task automatic cyc_a(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic fl, input string tag);
    bit do_pop, do_push;
    fa.in_valid  = iv;
    fa.in_data   = d;
    fa.out_ready = ordy;
    flush_a      = fl;
    #1;
    check({tag, ":count"},     32'(fa.count),     32'(qa.size()));
    check({tag, ":full"},      32'(fa.full),      32'(qa.size() == 4));
    check({tag, ":empty"},     32'(fa.empty),     32'(qa.size() == 0));
    check({tag, ":in_ready"},  32'(fa.in_ready),  32'(qa.size() < 4));
    check({tag, ":out_valid"}, 32'(fa.out_valid), 32'(qa.size() > 0));
    if (qa.size() > 0) check({tag, ":out_data"}, 32'(fa.out_data), 32'(qa[0]));
    if (fl) begin
      qa.delete();
    end else begin
      do_pop  = ordy && (qa.size() > 0);
      do_push = iv && (qa.size() < 4);
      if (do_pop)  void'(qa.pop_front());
      if (do_push) qa.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input logic iv, input logic [15:0] d, input logic ordy, input string tag);
    bit do_pop, do_push;
    fb.in_valid  = iv;
    fb.in_data   = d;
    fb.out_ready = ordy;
    #1;
    check({tag, ":count"},    32'(fb.count),    32'(qb.size()));
    check({tag, ":full"},     32'(fb.full),     32'(qb.size() == 8));
    check({tag, ":in_ready"}, 32'(fb.in_ready), 32'(qb.size() < 8));
    if (qb.size() > 0) check({tag, ":out_data"}, 32'(fb.out_data), 32'(qb[0]));
    do_pop  = ordy && (qb.size() > 0);
    do_push = iv && (qb.size() < 8);
    if (do_pop)  void'(qb.pop_front());
    if (do_push) qb.push_back(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fa.in_valid = 1'b0; fa.in_data = '0; fa.out_ready = 1'b0;
    fb.in_valid = 1'b0; fb.in_data = '0; fb.out_ready = 1'b0;

    // Reset values while held in reset.
    #12;
    check("rst0:count",     32'(fa.count),     32'd0);
    check("rst0:empty",     32'(fa.empty),     32'd1);
    check("rst0:full",      32'(fa.full),      32'd0);
    check("rst0:in_ready",  32'(fa.in_ready),  32'd1);
    check("rst0:out_valid", 32'(fa.out_valid), 32'd0);
    check("rst0:out_data",  32'(fa.out_data),  32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Async reset mid-stream with three words held.
    cyc_a(1'b1, 8'h11, 1'b0, 1'b0, "t1fill");
    cyc_a(1'b1, 8'h22, 1'b0, 1'b0, "t1fill");
    cyc_a(1'b1, 8'h33, 1'b0, 1'b0, "t1fill");
    fa.in_valid = 1'b0;
    check("t1pre:count", 32'(fa.count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    qa.delete();
    check("t1rst:count",     32'(fa.count),     32'd0);
    check("t1rst:empty",     32'(fa.empty),     32'd1);
    check("t1rst:in_ready",  32'(fa.in_ready),  32'd1);
    check("t1rst:out_valid", 32'(fa.out_valid), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc_a(1'b1, 8'hA5, 1'b0, 1'b0, "t1push");
    check("t1head", 32'(fa.out_data), 32'hA5);
    cyc_a(1'b0, 8'h00, 1'b1, 1'b0, "t1pop");

    // Fill past capacity, then drain in order.
    for (int unsigned i = 1; i <= 5; i++) cyc_a(1'b1, 8'(i), 1'b0, 1'b0, "t2fill");
    check("t2:full",  32'(fa.full),  32'd1);
    check("t2:count", 32'(fa.count), 32'd4);
    for (int unsigned i = 1; i <= 4; i++) begin
      check("t2:drain", 32'(fa.out_data), i);
      cyc_a(1'b0, 8'h00, 1'b1, 1'b0, "t2drain");
    end
    check("t2:empty", 32'(fa.empty), 32'd1);

    // Continuous push+pop at count 2 across pointer wrap.
    cyc_a(1'b1, 8'h40, 1'b0, 1'b0, "t3pre");
    cyc_a(1'b1, 8'h41, 1'b0, 1'b0, "t3pre");
    for (int unsigned i = 0; i < 10; i++) cyc_a(1'b1, 8'(8'h50 + i), 1'b1, 1'b0, "t3wrap");
    check("t3:count", 32'(fa.count), 32'd2);
    check("t3:head",  32'(fa.out_data), 32'h58);
    cyc_a(1'b0, 8'h00, 1'b1, 1'b0, "t3drain");
    cyc_a(1'b0, 8'h00, 1'b1, 1'b0, "t3drain");

    // Full with simultaneous push and pop: pop only, push next cycle.
    for (int unsigned i = 0; i < 4; i++) cyc_a(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "t4fill");
    cyc_a(1'b1, 8'h77, 1'b1, 1'b0, "t4both");
    check("t4:count3", 32'(fa.count), 32'd3);
    cyc_a(1'b1, 8'h77, 1'b0, 1'b0, "t4push");
    check("t4:count4", 32'(fa.count), 32'd4);
    for (int unsigned i = 0; i < 4; i++) cyc_a(1'b0, 8'h00, 1'b1, 1'b0, "t4drain");

    // Flush overrides concurrent push and pop.
    for (int unsigned i = 0; i < 3; i++) cyc_a(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, "t5fill");
    cyc_a(1'b1, 8'h99, 1'b1, 1'b1, "t5flush");
    check("t5:count", 32'(fa.count), 32'd0);
    check("t5:empty", 32'(fa.empty), 32'd1);
    cyc_a(1'b1, 8'h3C, 1'b0, 1'b0, "t5push");
    check("t5:data", 32'(fa.out_data), 32'h3C);
    cyc_a(1'b0, 8'h00, 1'b1, 1'b0, "t5pop");

    // Random traffic with occasional flush.
    for (int unsigned i = 0; i < 300; i++)
      cyc_a(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0), "rand");
    for (int unsigned i = 0; i < 4; i++) cyc_a(1'b0, 8'h00, 1'b1, 1'b0, "randdrain");

    // 16-bit x 8 instance round trip.
    for (int unsigned i = 0; i < 8; i++) cyc_b(1'b1, 16'(16'hBEEF + i), 1'b0, "t6fill");
    check("t6:count", 32'(fb.count), 32'd8);
    check("t6:full",  32'(fb.full),  32'd1);
    for (int unsigned i = 0; i < 8; i++) begin
      check("t6:data", 32'(fb.out_data), 32'(16'(16'hBEEF + i)));
      cyc_b(1'b0, 16'h0000, 1'b1, "t6drain");
    end
    check("t6:empty", 32'(fb.empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
